eth_pkt_rx: RTL and testbench
=============================

Name: eth_pkt_rx

Overview:
- Receive end of the 32-bit Ethernet word link; the counterpart of the load/busy transmit-side FSM.
- Parses a one-word header, filters on destination address and length, and forwards payload words into an internal FIFO.
- Presents payload on a valid/ready stream toward the consumer, and keeps good/drop packet counters.

Parameters:
- MY_ADDR, 8'h01: station address matched against header dest field.
- MAX_WORDS, 16: maximum legal payload length in words.
- FIFO_DEPTH, 32: output FIFO entries; power of 2, >= MAX_WORDS.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  link word valid; no backpressure toward link.
- in_sop  in  1  first word of packet (header), qualified by in_valid.
- in_eop  in  1  last word of packet, qualified by in_valid.
- in_data  in  32  link word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  32  payload word.
- out_last  out  1  final word of a forwarded packet.
- out_err  out  1  valid with out_last; packet length mismatch.
- rx_busy  out  1  high while state != IDLE.
- good_cnt  out  CNT_W  packets forwarded without error; saturating.
- drop_cnt  out  CNT_W  packets dropped or errored; saturating.

Behaviour:
- Reset: state IDLE, FIFO flushed, out_valid=0, rx_busy=0, counters=0. Reset mid-packet discards that packet with no count.
- Header word format: [31:24] dest, [23:16] src (ignored), [15:0] len in words.
- States: IDLE, PAYLOAD, DROP.
- IDLE, in_valid && in_sop: accept only if all hold:
  - dest==MY_ADDR;
  - 1<=len<=MAX_WORDS;
  - (FIFO_DEPTH - count) >= len, using the registered count with no credit for a same-cycle pop.
  - Accept -> load rem=len, go PAYLOAD.
  - Reject -> go DROP, or stay IDLE with drop_cnt+1 if in_eop is on the same word.
  - Reject also increments drop_cnt once, at the rejecting header.
- IDLE, in_valid without in_sop: word ignored, no count.
- PAYLOAD, each in_valid word is pushed and rem decrements:
  - rem==1 && in_eop: push last=1, err=0; good_cnt+1; go IDLE.
  - rem==1 && !in_eop: push last=1, err=1; drop_cnt+1; go DROP.
  - rem>1 && in_eop (early): push last=1, err=1; drop_cnt+1; go IDLE.
  - in_sop during PAYLOAD is treated as data; there is no resync.
- DROP: discard words until in_valid && in_eop, then go IDLE. No further count.
- FIFO:
  - Entry = {err, last, data}; first-word fall-through.
  - A word accepted at edge N is visible on out_* after edge N+1 (1-cycle latency).
  - Simultaneous push and pop are legal, including when full or empty.
  - The admission check guarantees no overflow. Pop when empty is ignored.
- Counters stick at all-ones.
- rx_busy is a combinational decode of the registered state.

Optional Feature:
- Macro ETH_RX_BCAST_EN.
- Defined: dest==8'hFF is also accepted as a match; other rules are unchanged.
- Undefined: only MY_ADDR matches; 8'hFF is dropped.

Decomposition:
- Package eth_pkg holds:
  - rx_state_t enum (IDLE, PAYLOAD, DROP);
  - header field bit positions;
  - ETH_ADDR_W=8, ETH_LEN_W=16;
  - ETH_BCAST_ADDR=8'hFF.
- Sub-module eth_sync_fifo (parameterised width/depth, FWFT, exposes count) holds the output buffer. The FSM and counters stay in eth_pkt_rx.

Test Plan:
- Header 32'h0102_0003 + 3 words, eop on 3rd, out_ready=1 -> 3 words out, last on 3rd, err=0; good_cnt=1; rx_busy high exactly 3 cycles.
- Header 32'h0502_0002 + 2 words -> no out_valid; drop_cnt=1. Len 0 and len 17 headers -> drop_cnt=3 total.
- Len 4, eop on payload word 2 -> 2 words out, 2nd last=1 err=1; drop_cnt+1; next good packet forwards normally.
- Len 2, eop on payload word 4 -> 2 words out, 2nd last/err=1; words 3-4 not output; rx_busy high until eop cycle.
- out_ready=0, send three len-16 packets -> first two accepted (count 32), third dropped; drop_cnt=1; draining then yields 32 words in order.
- Reset asserted mid-PAYLOAD -> next cycle out_valid=0, rx_busy=0, counters 0; a following good packet is forwarded. Repeat with ETH_RX_BCAST_EN and dest 8'hFF -> accepted with it, dropped without.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet word-link receive path.
//   rx_state_t     : receive FSM states
//   HDR_*          : header field bit positions within the 32-bit header word
//   ETH_ADDR_W/LEN : header field widths
//   ETH_BCAST_ADDR : broadcast destination address
package eth_pkg;

  localparam int unsigned ETH_ADDR_W = 8;
  localparam int unsigned ETH_LEN_W  = 16;

  localparam logic [ETH_ADDR_W-1:0] ETH_BCAST_ADDR = 8'hFF;

  // Header word layout: [31:24] dest, [23:16] src, [15:0] length in words.
  localparam int unsigned HDR_DEST_MSB = 31;
  localparam int unsigned HDR_DEST_LSB = 24;
  localparam int unsigned HDR_SRC_MSB  = 23;
  localparam int unsigned HDR_SRC_LSB  = 16;
  localparam int unsigned HDR_LEN_MSB  = 15;
  localparam int unsigned HDR_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StDrop
  } rx_state_t;

endpackage

// File: rtl/eth_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst    : clock, synchronous active-high reset (flushes contents)
//   wr_en       : push wr_data (ignored when full unless a pop happens in the same cycle)
//   wr_data     : word to push
//   rd_en       : pop the head word (ignored when empty)
//   rd_data     : head word, valid whenever empty is low
//   empty, full : occupancy flags
//   count       : number of stored words
// Depth must be a power of two so the pointers wrap naturally.
module eth_sync_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = rd_en && !empty;
  // A pop frees a slot in the same cycle, so push is legal even when full.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/eth_pkt_rx.sv
// Ethernet word-link packet receiver.
// Parses a one-word header, filters on destination and length, and forwards payload
// words into an output FIFO presented as a valid/ready stream. Keeps saturating
// good/drop packet counters.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/sop/eop   : link word qualifiers (no backpressure toward the link)
//   in_data            : link word
//   out_valid/ready    : payload stream handshake
//   out_data/last/err  : payload word, end-of-packet flag, length-mismatch flag
//   rx_busy            : FSM not idle
//   good_cnt, drop_cnt : packets forwarded cleanly / dropped or errored
// Build option: define ETH_RX_BCAST_EN to also accept destination 8'hFF.
module eth_pkt_rx
  import eth_pkg::*;
#(
  parameter logic [ETH_ADDR_W-1:0] MY_ADDR    = 8'h01,
  parameter int unsigned           MAX_WORDS  = 16,
  parameter int unsigned           FIFO_DEPTH = 32,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             rx_busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned WordW = 34;  // {err, last, data}
  localparam int unsigned FcntW = $clog2(FIFO_DEPTH) + 1;

  rx_state_t            state_q;
  logic [ETH_LEN_W-1:0] rem_q;
  logic                 push_q;
  logic [WordW-1:0]     push_word_q;
  logic [CNT_W-1:0]     good_cnt_q, drop_cnt_q;

  logic [ETH_ADDR_W-1:0] hdr_dest;
  logic [ETH_LEN_W-1:0]  hdr_len;
  logic                  dest_ok, len_ok, space_ok, hdr_ok;
  logic [31:0]           occupancy;

  logic [WordW-1:0] fifo_rd_data;
  logic             fifo_empty, fifo_full;
  logic [FcntW-1:0] fifo_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    hdr_dest = in_data[HDR_DEST_MSB:HDR_DEST_LSB];
    hdr_len  = in_data[HDR_LEN_MSB:HDR_LEN_LSB];
`ifdef ETH_RX_BCAST_EN
    dest_ok  = (hdr_dest == MY_ADDR) || (hdr_dest == ETH_BCAST_ADDR);
`else
    dest_ok  = (hdr_dest == MY_ADDR);
`endif
    len_ok   = (hdr_len != '0) && (32'(hdr_len) <= MAX_WORDS);
    // The word staged in push_q is not yet in the FIFO but already owns a slot.
    // No credit is taken for a pop happening in the same cycle.
    occupancy = 32'(fifo_count) + 32'(push_q);
    space_ok  = (32'(hdr_len) + occupancy) <= FIFO_DEPTH;
    hdr_ok    = dest_ok && len_ok && space_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      good_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_sop) begin
            if (hdr_ok) begin
              rem_q   <= hdr_len;
              state_q <= StPayload;
            end else begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
              state_q    <= in_eop ? StIdle : StDrop;
            end
          end
        end
        StPayload: begin
          // in_sop is plain data here; there is no resynchronisation.
          if (in_valid) begin
            push_q <= 1'b1;
            rem_q  <= rem_q - ETH_LEN_W'(1);
            if (rem_q == ETH_LEN_W'(1)) begin
              push_word_q <= {!in_eop, 1'b1, in_data};
              if (in_eop) begin
                good_cnt_q <= sat_inc(good_cnt_q);
                state_q    <= StIdle;
              end else begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
                state_q    <= StDrop;
              end
            end else if (in_eop) begin
              push_word_q <= {1'b1, 1'b1, in_data};
              drop_cnt_q  <= sat_inc(drop_cnt_q);
              state_q     <= StIdle;
            end else begin
              push_word_q <= {1'b0, 1'b0, in_data};
            end
          end
        end
        StDrop: begin
          if (in_valid && in_eop) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  eth_sync_fifo #(
    .Width (WordW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (push_word_q),
    .rd_en   (out_ready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_err   = fifo_rd_data[33];
  assign out_last  = fifo_rd_data[32];
  assign out_data  = fifo_rd_data[31:0];
  assign rx_busy   = (state_q != StIdle);
  assign good_cnt  = good_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Admission control guarantees the FIFO never overflows.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_eth_pkt_rx.sv
// Self-checking bench for eth_pkt_rx: directed scenarios plus randomized packets checked
// against a packet-level reference model of the receive rules.
module tb_eth_pkt_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sop, in_eop;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last, out_err, rx_busy;
  logic [31:0] out_data;
  logic [15:0] good_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_good, exp_drop;
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  eth_pkt_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_err   (out_err),
    .rx_busy   (rx_busy),
    .good_cnt  (good_cnt),
    .drop_cnt  (drop_cnt)
  );

  // Collect every handshaken output word, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back({out_err, out_last, out_data});
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
    in_valid = v; in_sop = s; in_eop = e; in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_good = 0;
    exp_drop = 0;
  endtask

  function automatic bit dest_match(input logic [7:0] d);
`ifdef ETH_RX_BCAST_EN
    return (d == 8'h01) || (d == 8'hFF);
`else
    return d == 8'h01;
`endif
  endfunction

  // Reference model: decides the packet's fate from the header rules and the words
  // that will be sent, then drives it. nwords >= 1, eop on the last word.
  task automatic send_pkt(input logic [7:0] dest, input int len, input int nwords,
                          input int max_gap);
    int occ, out_n;
    bit acc, last, err;
    logic [31:0] w;
    occ = exp_q.size() - obs_q.size();
    acc = dest_match(dest) && (len >= 1) && (len <= 16) && ((32 - occ) >= len);
    if (!acc) exp_drop++;
    else if (nwords == len) exp_good++;
    else exp_drop++;
    out_n = (nwords < len) ? nwords : len;
    drive(1'b1, 1'b1, 1'b0, {dest, 8'($urandom), 16'(len)});
    for (int i = 0; i < nwords; i++) begin
      repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, 1'b0, 32'h0);
      w = $urandom;
      drive(1'b1, ($urandom_range(0, 7) == 0), (i == nwords - 1), w);
      if (acc && i < out_n) begin
        last = (i == out_n - 1);
        err  = last && (nwords != len);
        exp_q.push_back({err, last, w});
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 32'h0;
    out_ready = 1'b1;
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset rx_busy: got %b want 0", rx_busy); end
    checks++;
    if (good_cnt !== 16'd0) begin errors++; $display("FAIL reset good_cnt: got %0d want 0", good_cnt); end
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_basic();
    int busy = 0;
    logic [31:0] w;
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0102_0003);
    busy += int'(rx_busy);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      drive(1'b1, 1'b0, (i == 2), w);
      busy += int'(rx_busy);
      exp_q.push_back({1'b0, (i == 2), w});
    end
    exp_good++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      busy += int'(rx_busy);
    end
    wait_drain(200);
    checks++;
    if (busy != 3) begin errors++; $display("FAIL basic busy cycles: got %0d want 3", busy); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic word count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic word %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL basic good_cnt: got %0d want %0d", good_cnt, exp_good); end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL basic drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_filter();
    apply_reset();
    send_pkt(8'h05, 2, 2, 0);
    // Length-0 header carrying eop: rejected, FSM stays idle.
    drive(1'b1, 1'b1, 1'b1, 32'h0102_0000);
    exp_drop++;
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL filter eop-header busy: got %b want 0", rx_busy); end
    send_pkt(8'h01, 17, 17, 0);
    wait_drain(100);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL filter output words: got %0d want 0", obs_q.size()); end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL filter drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    checks++;
    if (good_cnt !== 16'd0) begin errors++; $display("FAIL filter good_cnt: got %0d want 0", good_cnt); end
  endtask

  task automatic test_len_mismatch();
    int busy = 0;
    logic [31:0] w;
    apply_reset();
    send_pkt(8'h01, 4, 2, 1);   // early eop
    send_pkt(8'h01, 3, 3, 1);   // following good packet
    // Late eop: len 2, eop on the fourth payload word.
    drive(1'b1, 1'b1, 1'b0, 32'h0177_0002);
    busy += int'(rx_busy);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      drive(1'b1, 1'b0, (i == 3), w);
      busy += int'(rx_busy);
      if (i < 2) exp_q.push_back({(i == 1), (i == 1), w});
    end
    exp_drop++;
    wait_drain(200);
    checks++;
    if (busy != 4) begin errors++; $display("FAIL late-eop busy cycles: got %0d want 4", busy); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mismatch word count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mismatch word %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL mismatch good_cnt: got %0d want %0d", good_cnt, exp_good); end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL mismatch drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(8'h01, 16, 16, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL backpressure out_valid: got %b want 1", out_valid); end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL backpressure drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    out_ready = 1'b1;
    wait_drain(200);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL backpressure word count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL backpressure word %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL backpressure good_cnt: got %0d want %0d", good_cnt, exp_good); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_pkt(8'h01, 2, 2, 0);
    drive(1'b1, 1'b1, 1'b0, 32'h0102_0004);
    drive(1'b1, 1'b0, 1'b0, 32'hAAAA_0001);
    drive(1'b1, 1'b0, 1'b0, 32'hAAAA_0002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); exp_good = 0; exp_drop = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL midreset rx_busy: got %b want 0", rx_busy); end
    checks++;
    if (good_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset counters: got %0d/%0d want 0/0", good_cnt, drop_cnt);
    end
    send_pkt(8'h01, 3, 3, 0);
    send_pkt(8'hFF, 2, 2, 0);
    wait_drain(200);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midreset word count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midreset word %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL bcast counters: got %0d/%0d want %0d/%0d", good_cnt, drop_cnt, exp_good, exp_drop);
    end
  endtask

  task automatic test_random();
    logic [7:0] dests [5];
    int len, nw;
    dests[0] = 8'h01; dests[1] = 8'h01; dests[2] = 8'h01; dests[3] = 8'h05; dests[4] = 8'hFF;
    apply_reset();
    for (int p = 0; p < 60; p++) begin
      if (p == 30) rand_ready = 1'b1;
      len = $urandom_range(0, 18);
      nw  = $urandom_range(1, len + 2);
      // Idle-state junk words without sop must be ignored.
      repeat ($urandom_range(0, 2)) drive(1'($urandom), 1'b0, 1'($urandom), $urandom);
      send_pkt(dests[$urandom_range(0, 4)], len, nw, 2);
      if (rand_ready) wait_drain(400);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain(400);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random word count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL random word %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL random good_cnt: got %0d want %0d", good_cnt, exp_good); end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL random drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_len_mismatch();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
